// File: rtl/cdb_arbiter.sv
// Rotating-priority arbiter that maps up to NUM_FU completion requests onto
// CDB_W registered common-data-bus broadcast slots each cycle.
module cdb_arbiter #(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 3,
    parameter int PR_W   = 6,
    parameter int XLEN   = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_FU-1:0]                 req_valid,
    input  logic [NUM_FU-1:0][PR_W-1:0]       req_pr,
    input  logic [NUM_FU-1:0][XLEN-1:0]       req_value,
    input  logic                              flush,
    output logic [NUM_FU-1:0]                 fu_stall,
    output logic [CDB_W-1:0]                  cdb_valid,
    output logic [CDB_W-1:0][PR_W-1:0]        cdb_tag,
    output logic [CDB_W-1:0][XLEN-1:0]        cdb_value,
    output logic [$clog2(NUM_FU)-1:0]         rr_ptr
);

    localparam int PW = $clog2(NUM_FU);
    localparam int CW = $clog2(CDB_W + 1);
    localparam logic [CW-1:0] SLOTS    = CW'(CDB_W);
    localparam logic [PW:0]   NFU      = (PW + 1)'(NUM_FU);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_FU - 1);

    logic [PW-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [CDB_W-1:0]              vld_q, vld_d;
    logic [CDB_W-1:0][PR_W-1:0]    tag_q, tag_d;
    logic [CDB_W-1:0][XLEN-1:0]    val_q, val_d;

    logic [NUM_FU-1:0]             cand;
    logic [NUM_FU-1:0]             granted;
    logic [CW-1:0]                 n_grant;
    logic [PW:0]                   idx_w;
    logic [PW-1:0]                 idx;
    logic [PW-1:0]                 last_idx;

    // Zero-tag requests need no writeback, so they never compete for a slot.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand[i] = req_valid[i] & (req_pr[i] != '0);
        end
    end

    always_comb begin
        granted  = '0;
        vld_d    = '0;
        tag_d    = '0;
        val_d    = '0;
        n_grant  = '0;
        last_idx = rr_ptr_q;
        idx_w    = '0;
        idx      = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            idx_w = {1'b0, rr_ptr_q} + (PW + 1)'(j);
            if (idx_w >= NFU) begin
                idx_w = idx_w - NFU;
            end
            idx = idx_w[PW-1:0];
            if (!flush && cand[idx] && (n_grant < SLOTS)) begin
                granted[idx]   = 1'b1;
                vld_d[n_grant] = 1'b1;
                tag_d[n_grant] = req_pr[idx];
                val_d[n_grant] = req_value[idx];
                last_idx       = idx;
                n_grant        = n_grant + CW'(1);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (n_grant != '0) begin
            rr_ptr_d = (last_idx == LAST_IDX) ? '0 : last_idx + PW'(1);
        end
    end

    // A squashed FU must not be told to hold, hence the flush mask.
    assign fu_stall = cand & ~granted & {NUM_FU{~flush}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            tag_q    <= '0;
            val_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            val_q    <= val_d;
        end
    end

    assign cdb_valid = vld_q;
    assign cdb_tag   = tag_q;
    assign cdb_value = val_q;
    assign rr_ptr    = rr_ptr_q;

endmodule
